block_mem_ctrl: RTL and testbench
=================================

Name: block_mem_ctrl

Overview:
- Lower-level memory stage directly downstream of the 16KB write-back cache.
- Serves whole 128-bit block requests: write-back of dirty victims and refill on miss.
- Uses the cache's Req_Low/Wr_Low/A_Low/DO_Low/DI_Low/Rdy_Low handshake and has a configurable access latency.
- Holds an internal block array that is zero-cleared by a sweep after reset.

Parameters:
- ADDR_W, 28: block address width (Tag 18 + Index 10), matches `Width_of_A_Low.
- BLK_W, 128: block width in bits, matches `Memory_Block_Size.
- DEPTH_LOG2, 10: log2 of the number of stored blocks. The array is indexed by A_Low[DEPTH_LOG2-1:0]; upper address bits alias.
- RD_LAT, 4: cycles from request accept to Rdy_Low for reads. Legal range 1..255.
- WR_LAT, 4: cycles from request accept to Rdy_Low for writes. Legal range 1..255.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-low.
- Req_Low  input  1  request from cache.
- Wr_Low  input  1  1 = block write (write-back), 0 = block read (refill).
- A_Low  input  ADDR_W  block address.
- DO_Low  input  BLK_W  write data from cache.
- Rdy_Low  output  1  one-cycle completion pulse.
- DI_Low  output  BLK_W  read data to cache.
- Busy  output  1  high in CLEAR, BUSY and DONE states.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to CLEAR, clear pointer = 0.
  - Rdy_Low=0, DI_Low=0, Busy=1, latency counter=0, latched request cleared.
  - An in-flight operation is discarded; a write not yet committed is lost.
- State CLEAR:
  - Each cycle writes 0 to array[ptr] and increments ptr.
  - After entry 2^DEPTH_LOG2-1 is written, the next state is IDLE. The sweep takes exactly 2^DEPTH_LOG2 cycles.
  - Req_Low is ignored, not queued. The cache sees Rdy_Low=0 and keeps waiting; the request is accepted on the first IDLE cycle.
- State IDLE:
  - Busy=0.
  - If Req_Low=1, latch Wr_Low, A_Low and DO_Low, then go to BUSY with counter = (Wr ? WR_LAT : RD_LAT) - 1.
- State BUSY:
  - Latched fields are used; input changes are ignored.
  - Counter decrements each cycle. When the counter is 0, the next state is DONE.
  - If LAT=1, the state goes straight from accept to DONE.
  - Req_Low dropping during BUSY does not abort; the operation completes and Rdy_Low still pulses.
- Entry to DONE:
  - Write: array[idx] <= latched data on the edge entering DONE.
  - Read: DI_Low <= array[idx] on the same edge.
  - Rdy_Low=1 for exactly the DONE cycle, then the state returns to IDLE.
- Timing: with the request accepted at edge T, Rdy_Low is high in cycle T+LAT (edge T+LAT to T+LAT+1).
- DI_Low outside Rdy_Low:
  - Holds the last read value.
  - Is unchanged by writes, including a write to the same index as the previous read.
- Back-to-back operations:
  - The cache must change its request or drop Req_Low in the cycle after Rdy_Low.
  - IDLE samples fresh, so a write-back immediately followed by a refill with Req_Low held high is served as two operations with 1 idle cycle between them.
  - A Req_Low still high with unchanged fields is re-served. This is idempotent and is a requester protocol error.
- Read of an index written by the immediately preceding operation returns the new data. The write commits before the read's DONE edge.
- Minimum turnaround: LAT+2 cycles per operation (accept, LAT-1 busy cycles, DONE, IDLE).
- Illegal RD_LAT/WR_LAT (0 or >255): elaboration error via a generate-time check.

Test Plan:
- Reset sweep: hold rst=0 for 2 cycles, then release with DEPTH_LOG2=4 and Req_Low=1 (read of 0x0000005) from release → Busy=1 for 16 cycles, request accepted on the 17th cycle, Rdy_Low 4 cycles later, DI_Low=0.
- Write then read: write A_Low=0x0000123, DO_Low=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D; then read the same address → each Rdy_Low exactly 4 cycles after accept, one cycle wide; read returns the written value.
- Write-back followed by refill with Req_Low held high:
  - Stimulus: write 0x00AB003 then read 0x0120003 (same index, DEPTH_LOG2=10).
  - Two Rdy_Low pulses 6 cycles apart.
  - Read returns the just-written block because of aliasing.
  - DI_Low unchanged after the write's pulse.
- Latency and abort: RD_LAT=1, WR_LAT=7, requester drops Req_Low 2 cycles after accepting a write → Rdy_Low still pulses at T+7 and the data is committed; a following read shows Rdy_Low at T'+1.
- Input change during BUSY: change A_Low and DO_Low every cycle while BUSY → the latched address and data are used; the array holds the original value.
- Reset mid-write: assert rst at T+2 of a WR_LAT=4 write → no Rdy_Low; after the sweep, a read of that address returns 0.

Source files
------------

// File: rtl/block_mem_ctrl.sv
// Block-granular backing memory behind the write-back cache: serves whole-block
// write-backs and refills with a fixed per-direction access latency, and
// zero-clears its array with a sweep after every reset.
module block_mem_ctrl #(
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned BLK_W      = 128,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned WR_LAT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Req_Low,
  input  logic              Wr_Low,
  input  logic [ADDR_W-1:0] A_Low,
  input  logic [BLK_W-1:0]  DO_Low,
  output logic              Rdy_Low,
  output logic [BLK_W-1:0]  DI_Low,
  output logic              Busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0]      RD_CNT   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]      WR_CNT   = CNT_W'(WR_LAT - 1);
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = DEPTH_LOG2'(DEPTH - 1);

  // Latencies are counted in an 8-bit down-counter; reject anything it cannot hold.
  if (RD_LAT < 1 || RD_LAT > 255) begin : g_bad_rd_lat
    $error("block_mem_ctrl: RD_LAT must be in 1..255");
  end
  if (WR_LAT < 1 || WR_LAT > 255) begin : g_bad_wr_lat
    $error("block_mem_ctrl: WR_LAT must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [DEPTH_LOG2-1:0]  ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   wr_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [BLK_W-1:0]       data_q;
  logic                   rdy_q;
  logic [BLK_W-1:0]       di_q;
  logic                   busy_q;
  logic [BLK_W-1:0]       mem_q [DEPTH];

  // Upper address bits alias onto the array; they carry no state here.
  logic unused_addr_c;
  assign unused_addr_c = ^A_Low[ADDR_W-1:DEPTH_LOG2];

  // Controller FSM, request latch, array port and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      di_q    <= '0;
      busy_q  <= 1'b1;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          mem_q[ptr_q] <= '0;
          ptr_q        <= ptr_q + DEPTH_LOG2'(1);
          if (ptr_q == PTR_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (Req_Low) begin
            wr_q    <= Wr_Low;
            idx_q   <= A_Low[DEPTH_LOG2-1:0];
            data_q  <= DO_Low;
            cnt_q   <= Wr_Low ? WR_CNT : RD_CNT;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            // The array access happens on the edge that enters DONE.
            if (wr_q) begin
              mem_q[idx_q] <= data_q;
            end else begin
              di_q <= mem_q[idx_q];
            end
            rdy_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign Rdy_Low = rdy_q;
  assign DI_Low  = di_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Directed bench for block_mem_ctrl: three instances cover a small swept array
// at latency 4, the full-size array for aliasing, and asymmetric latencies.
module tb_block_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_a, req_b, req_c;
  logic         wr;
  logic [27:0]  addr;
  logic [127:0] dout;
  logic         rdy_a, rdy_b, rdy_c;
  logic         busy_a, busy_b, busy_c;
  logic [127:0] di_a, di_b, di_c;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D4 = 128'hFEEDFACE_00000001_00000002_00000003;
  localparam logic [127:0] D5 = 128'h12345678_9ABCDEF0_12345678_9ABCDEF0;

  always #5 clk = ~clk;

  block_mem_ctrl #(.DEPTH_LOG2(4)) u_a (
    .clk(clk), .rst(rst), .Req_Low(req_a), .Wr_Low(wr), .A_Low(addr), .DO_Low(dout),
    .Rdy_Low(rdy_a), .DI_Low(di_a), .Busy(busy_a));

  block_mem_ctrl u_b (
    .clk(clk), .rst(rst), .Req_Low(req_b), .Wr_Low(wr), .A_Low(addr), .DO_Low(dout),
    .Rdy_Low(rdy_b), .DI_Low(di_b), .Busy(busy_b));

  block_mem_ctrl #(.DEPTH_LOG2(4), .RD_LAT(1), .WR_LAT(7)) u_c (
    .clk(clk), .rst(rst), .Req_Low(req_c), .Wr_Low(wr), .A_Low(addr), .DO_Low(dout),
    .Rdy_Low(rdy_c), .DI_Low(di_c), .Busy(busy_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_of(input int k);
    case (k)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  task automatic set_req(input int k, input logic v);
    case (k)
      0:       req_a = v;
      1:       req_b = v;
      default: req_c = v;
    endcase
  endtask

  // One request held for a single accept edge; lat = cycles from accept to Rdy_Low.
  task automatic run_op(input int k, input logic w, input logic [27:0] a,
                        input logic [127:0] d, output int lat);
    set_req(k, 1'b1);
    wr = w; addr = a; dout = d;
    tick();
    set_req(k, 1'b0);
    lat = 0;
    while (rdy_of(k) !== 1'b1 && lat < 300) begin
      tick();
      lat++;
    end
    if (rdy_of(k) !== 1'b1) lat = -1;
    tick();
  endtask

  task automatic test_reset();
    int busy_cnt;
    int lat;
    rst = 1'b0; req_a = 1'b1; wr = 1'b0; addr = 28'h0000005; dout = '0;
    tick();
    tick();
    n_vec++;
    if ({rdy_a, busy_a, busy_b, busy_c} !== 4'b0111) begin
      n_err++; $display("FAIL reset_flags: got %b want 0111", {rdy_a, busy_a, busy_b, busy_c});
    end
    n_vec++;
    if (di_a !== '0) begin
      n_err++; $display("FAIL reset_di: got %h want 0", di_a);
    end
    rst = 1'b1;
    busy_cnt = 0;
    while (busy_a === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      tick();
    end
    n_vec++;
    if (busy_cnt !== 16) begin
      n_err++; $display("FAIL sweep_len: got %0d want 16", busy_cnt);
    end
    tick();
    req_a = 1'b0;
    lat = 0;
    while (rdy_a !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== 4) begin
      n_err++; $display("FAIL sweep_read_lat: got %0d want 4", lat);
    end
    n_vec++;
    if (di_a !== '0) begin
      n_err++; $display("FAIL sweep_read_data: got %h want 0", di_a);
    end
    tick();
    n_vec++;
    if (rdy_a !== 1'b0) begin
      n_err++; $display("FAIL sweep_rdy_width: got %b want 0", rdy_a);
    end
  endtask

  task automatic test_write_read();
    int lat;
    run_op(0, 1'b1, 28'h0000123, D1, lat);
    n_vec++;
    if (lat !== 4) begin
      n_err++; $display("FAIL wr_lat: got %0d want 4", lat);
    end
    n_vec++;
    if (rdy_a !== 1'b0) begin
      n_err++; $display("FAIL wr_rdy_width: got %b want 0", rdy_a);
    end
    run_op(0, 1'b0, 28'h0000123, '0, lat);
    n_vec++;
    if (lat !== 4) begin
      n_err++; $display("FAIL rd_lat: got %0d want 4", lat);
    end
    n_vec++;
    if (di_a !== D1) begin
      n_err++; $display("FAIL rd_data: got %h want %h", di_a, D1);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    int gap;
    cnt = 0;
    while (busy_b !== 1'b0 && cnt < 1100) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (busy_b !== 1'b0) begin
      n_err++; $display("FAIL big_sweep_done: got %b want 0", busy_b);
    end
    req_b = 1'b1; wr = 1'b1; addr = 28'h00AB003; dout = D2;
    tick();
    cnt = 0;
    while (rdy_b !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt !== 4) begin
      n_err++; $display("FAIL b2b_wr_lat: got %0d want 4", cnt);
    end
    n_vec++;
    if (di_b !== '0) begin
      n_err++; $display("FAIL b2b_di_at_wr: got %h want 0", di_b);
    end
    tick();
    n_vec++;
    if (di_b !== '0) begin
      n_err++; $display("FAIL b2b_di_after_wr: got %h want 0", di_b);
    end
    wr = 1'b0; addr = 28'h0120003; dout = '1;
    gap = 1;
    while (rdy_b !== 1'b1 && gap < 50) begin
      tick();
      gap++;
    end
    n_vec++;
    if (gap !== 6) begin
      n_err++; $display("FAIL b2b_gap: got %0d want 6", gap);
    end
    n_vec++;
    if (di_b !== D2) begin
      n_err++; $display("FAIL b2b_alias_data: got %h want %h", di_b, D2);
    end
    req_b = 1'b0;
    tick();
  endtask

  task automatic test_latency_abort();
    int lat;
    req_c = 1'b1; wr = 1'b1; addr = 28'h0000009; dout = D3;
    tick();
    tick();
    tick();
    req_c = 1'b0;
    lat = 2;
    while (rdy_c !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== 7) begin
      n_err++; $display("FAIL abort_wr_lat: got %0d want 7", lat);
    end
    tick();
    run_op(2, 1'b0, 28'h0000009, '0, lat);
    n_vec++;
    if (lat !== 1) begin
      n_err++; $display("FAIL lat1_rd: got %0d want 1", lat);
    end
    n_vec++;
    if (di_c !== D3) begin
      n_err++; $display("FAIL abort_committed: got %h want %h", di_c, D3);
    end
  endtask

  task automatic test_busy_inputs();
    int lat;
    req_a = 1'b1; wr = 1'b1; addr = 28'h0000007; dout = D4;
    tick();
    req_a = 1'b0;
    lat = 0;
    while (rdy_a !== 1'b1 && lat < 50) begin
      addr = 28'(8 + lat);
      dout = D1 ^ {4{32'(lat)}};
      wr   = ~wr;
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== 4) begin
      n_err++; $display("FAIL busy_in_lat: got %0d want 4", lat);
    end
    tick();
    run_op(0, 1'b0, 28'h0000007, '0, lat);
    n_vec++;
    if (di_a !== D4) begin
      n_err++; $display("FAIL busy_in_latched: got %h want %h", di_a, D4);
    end
    run_op(0, 1'b0, 28'h0000008, '0, lat);
    n_vec++;
    if (di_a !== '0) begin
      n_err++; $display("FAIL busy_in_stray_write: got %h want 0", di_a);
    end
  endtask

  task automatic test_reset_mid_write();
    int  cnt;
    int  lat;
    logic seen;
    req_a = 1'b1; wr = 1'b1; addr = 28'h000000A; dout = D5;
    tick();
    req_a = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if ({rdy_a, busy_a} !== 2'b01) begin
      n_err++; $display("FAIL midrst_flags: got %b want 01", {rdy_a, busy_a});
    end
    tick();
    rst = 1'b1;
    seen = 1'b0;
    cnt = 0;
    while (busy_a !== 1'b0 && cnt < 2000) begin
      seen = seen | rdy_a;
      tick();
      cnt++;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL midrst_no_rdy: got %b want 0", seen);
    end
    n_vec++;
    if (cnt !== 16) begin
      n_err++; $display("FAIL midrst_sweep_len: got %0d want 16", cnt);
    end
    run_op(0, 1'b0, 28'h000000A, '0, lat);
    n_vec++;
    if (lat !== 4) begin
      n_err++; $display("FAIL midrst_rd_lat: got %0d want 4", lat);
    end
    n_vec++;
    if (di_a !== '0) begin
      n_err++; $display("FAIL midrst_lost_write: got %h want 0", di_a);
    end
    run_op(2, 1'b0, 28'h0000009, '0, lat);
    n_vec++;
    if (di_c !== '0) begin
      n_err++; $display("FAIL midrst_cleared: got %h want 0", di_c);
    end
  endtask

  initial begin
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    wr = 1'b0; addr = '0; dout = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_latency_abort();
    test_busy_inputs();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
